// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
// Optional feature macro used by booth_seq_mult: MULT_ZERO_BYPASS_EN.
package booth_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Action selected by the Booth pair {q[0], q_1}; pair 2'b11 also means NOP.
    typedef enum logic [1:0] {
        BOOTH_NOP = 2'b00,
        BOOTH_ADD = 2'b01,
        BOOTH_SUB = 2'b10
    } booth_op_t;

    function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
        booth_op_t op;
        case ({q0, q_1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

    // Step counter must hold the value WIDTH itself.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/booth_seq_mult_if.sv
// Operand/result bundle between the operand load registers and booth_seq_mult.
interface booth_seq_mult_if #(
    parameter int WIDTH = booth_pkg::DEFAULT_WIDTH
);

    logic                       start;
    logic signed [WIDTH-1:0]    M;
    logic signed [WIDTH-1:0]    Q;
    logic                       busy;
    logic                       done;
    logic signed [2*WIDTH-1:0]  P;

    modport master (
        output start, M, Q,
        input  busy, done, P
    );

    modport slave (
        input  start, M, Q,
        output busy, done, P
    );

endinterface

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: add/sub of M into A, then an
// arithmetic right shift of the concatenation {A, Q, q_1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_1_next
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = a;
        case (booth_decode(q[0], q_1))
            BOOTH_ADD: sum = a + m;
            BOOTH_SUB: sum = a - m;
            default:   sum = a;
        endcase
    end

    genvar gi;

    // A keeps its sign bit; the bit shifted out of A enters the top of Q.
    assign a_next[WIDTH] = sum[WIDTH];
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_a_shift
            assign a_next[gi] = sum[gi+1];
        end
    endgenerate

    assign q_next[WIDTH-1] = sum[0];
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_q_shift
            assign q_next[gi] = q[gi+1];
        end
    endgenerate

    assign q_1_next = q[0];

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential signed radix-2 Booth multiplier: one step per clock, WIDTH+1 latency.
// Define MULT_ZERO_BYPASS_EN to finish zero-operand products in a single cycle.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    booth_seq_mult_if.slave   bus
);

    localparam int CW = count_width(WIDTH);

    state_t              state_reg, state_next;
    logic [WIDTH:0]      m_reg, m_next;
    logic [WIDTH:0]      a_reg, a_next;
    logic [WIDTH-1:0]    q_reg, q_next;
    logic                q_1_reg, q_1_next;
    logic [CW-1:0]       count_reg, count_next;
    logic [2*WIDTH-1:0]  p_reg, p_next;

    logic [WIDTH:0]      a_step;
    logic [WIDTH-1:0]    q_step;
    logic                q_1_step;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a        (a_reg),
        .q        (q_reg),
        .q_1      (q_1_reg),
        .m        (m_reg),
        .a_next   (a_step),
        .q_next   (q_step),
        .q_1_next (q_1_step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            m_reg     <= '0;
            a_reg     <= '0;
            q_reg     <= '0;
            q_1_reg   <= 1'b0;
            count_reg <= '0;
            p_reg     <= '0;
        end else begin
            state_reg <= state_next;
            m_reg     <= m_next;
            a_reg     <= a_next;
            q_reg     <= q_next;
            q_1_reg   <= q_1_next;
            count_reg <= count_next;
            p_reg     <= p_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        m_next     = m_reg;
        a_next     = a_reg;
        q_next     = q_reg;
        q_1_next   = q_1_reg;
        count_next = count_reg;
        p_next     = p_reg;

        case (state_reg)
            IDLE, DONE: begin
                // DONE is a single-cycle state; a start here chains the next operation.
                state_next = IDLE;
                if (bus.start) begin
                    m_next     = {bus.M[WIDTH-1], bus.M};
                    a_next     = '0;
                    q_next     = bus.Q;
                    q_1_next   = 1'b0;
                    count_next = CW'(WIDTH);
                    state_next = CALC;
`ifdef MULT_ZERO_BYPASS_EN
                    if (bus.M == '0 || bus.Q == '0) begin
                        state_next = DONE;
                        p_next     = '0;
                    end
`endif
                end
            end

            CALC: begin
                a_next     = a_step;
                q_next     = q_step;
                q_1_next   = q_1_step;
                count_next = count_reg - CW'(1);
                // Product is taken from the post-shift values of the final step.
                if (count_reg == CW'(1)) begin
                    state_next = DONE;
                    p_next     = {a_step[WIDTH-1:0], q_step};
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign bus.busy = (state_reg == CALC);
    assign bus.done = (state_reg == DONE);
    assign bus.P    = p_reg;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed self-checking bench for booth_seq_mult (WIDTH=8); honours MULT_ZERO_BYPASS_EN.
module tb_booth_seq_mult;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

`ifdef MULT_ZERO_BYPASS_EN
    localparam int ZERO_DONE = 1;
`else
    localparam int ZERO_DONE = 9;
`endif

    booth_seq_mult_if #(.WIDTH(8)) bus ();

    booth_seq_mult #(
        .WIDTH (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle 0 is the clock period whose ending edge samples start; cycle k follows edge k.
    task automatic run_op(input string name, input logic [7:0] m, input logic [7:0] q,
                          input logic [15:0] exp_p, input int exp_done);
        int          cyc;
        int          done_cyc;
        int          busy_bad;
        int          overlap;
        logic [15:0] p_seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.M     = m;
        bus.Q     = q;
        @(negedge clk);
        bus.start = 1'b0;
        bus.M     = 8'h5A;
        bus.Q     = 8'hA5;
        cyc = 1; done_cyc = -1; busy_bad = 0; overlap = 0;
        while (cyc <= 20 && done_cyc < 0) begin
            if (bus.busy && bus.done) overlap++;
            if (bus.done === 1'b1) begin
                done_cyc = cyc;
            end else begin
                if (bus.busy !== (cyc < exp_done)) busy_bad++;
                @(negedge clk);
                cyc++;
            end
        end
        p_seen = bus.P;
        $display("[TB] %s: M=%h Q=%h P=%h done_cycle=%0d", name, m, q, p_seen, done_cyc);
        tests++;
        if (done_cyc != exp_done) begin
            fails++;
            $display("FAIL %s_latency: done in cycle %0d, expected %0d", name, done_cyc, exp_done);
        end
        tests++;
        if (busy_bad != 0) begin
            fails++;
            $display("FAIL %s_busy: %0d cycles with wrong busy, expected 0", name, busy_bad);
        end
        tests++;
        if (overlap != 0) begin
            fails++;
            $display("FAIL %s_overlap: busy&done seen %0d times, expected 0", name, overlap);
        end
        tests++;
        if (p_seen !== exp_p) begin
            fails++;
            $display("FAIL %s_product: P=%h, expected %h", name, p_seen, exp_p);
        end
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b0) begin
            fails++;
            $display("FAIL %s_done_pulse: done=%b after DONE cycle, expected 0", name, bus.done);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (bus.P !== exp_p) begin
            fails++;
            $display("FAIL %s_hold: P=%h, expected %h", name, bus.P, exp_p);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.start = 1'b1;
        bus.M     = 8'd3;
        bus.Q     = 8'd4;
        repeat (3) @(negedge clk);
        $display("[TB] reset: busy=%b done=%b P=%h", bus.busy, bus.done, bus.P);
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: busy=%b, expected 0", bus.busy);
        end
        tests++;
        if (bus.done !== 1'b0) begin
            fails++;
            $display("FAIL reset_done: done=%b, expected 0", bus.done);
        end
        tests++;
        if (bus.P !== 16'h0000) begin
            fails++;
            $display("FAIL reset_p: P=%h, expected 0000", bus.P);
        end
        bus.start = 1'b0;
        reset_n   = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        run_op("basic_3x4", 8'd3, 8'd4, 16'h000C, 9);
    endtask

    task automatic test_signed();
        run_op("neg3x4", 8'hFD, 8'h04, 16'hFFF4, 9);
        run_op("127xneg128", 8'h7F, 8'h80, 16'hC080, 9);
    endtask

    task automatic test_extra_bit();
        run_op("neg128xneg128", 8'h80, 8'h80, 16'h4000, 9);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ms [4]      = '{8'd7, 8'h9C, 8'd12, 8'd2};
        logic [7:0]  qs [4]      = '{8'hFB, 8'h9C, 8'd11, 8'd3};
        logic [15:0] ps [4]      = '{16'hFFDD, 16'h2710, 16'h0084, 16'h0006};
        int          exp_cyc [3] = '{9, 18, 27};
        int          n;
        int          overlap;
        int          wait_cyc;
        n = 0; overlap = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.M     = ms[0];
        bus.Q     = qs[0];
        for (int cyc = 1; cyc < 30; cyc++) begin
            @(negedge clk);
            if (bus.busy && bus.done) overlap++;
            if (bus.done === 1'b1) begin
                if (n < 3) begin
                    $display("[TB] b2b[%0d]: P=%h done_cycle=%0d", n, bus.P, cyc);
                    tests++;
                    if (cyc != exp_cyc[n]) begin
                        fails++;
                        $display("FAIL b2b_latency_%0d: done in cycle %0d, expected %0d", n, cyc, exp_cyc[n]);
                    end
                    tests++;
                    if (bus.P !== ps[n]) begin
                        fails++;
                        $display("FAIL b2b_product_%0d: P=%h, expected %h", n, bus.P, ps[n]);
                    end
                end
                n++;
                if (n < 4) begin
                    bus.M = ms[n];
                    bus.Q = qs[n];
                end
            end else begin
                // Operands wobble while busy; they must be ignored.
                bus.M = 8'($urandom);
                bus.Q = 8'($urandom);
            end
        end
        bus.start = 1'b0;
        tests++;
        if (n != 3) begin
            fails++;
            $display("FAIL b2b_count: %0d results in 30 cycles, expected 3", n);
        end
        wait_cyc = 0;
        while (bus.done !== 1'b1 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        $display("[TB] b2b[3]: P=%h after %0d extra cycles", bus.P, wait_cyc);
        tests++;
        if (bus.done !== 1'b1 || bus.P !== ps[3]) begin
            fails++;
            $display("FAIL b2b_product_3: done=%b P=%h, expected done=1 P=%h", bus.done, bus.P, ps[3]);
        end
        tests++;
        if (overlap != 0) begin
            fails++;
            $display("FAIL b2b_overlap: busy&done seen %0d times, expected 0", overlap);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.start = 1'b1;
        bus.M     = 8'd3;
        bus.Q     = 8'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL midreset_pre_busy: busy=%b in cycle 4, expected 1", bus.busy);
        end
        #2 reset_n = 1'b0;
        #1;
        $display("[TB] mid-CALC reset: busy=%b done=%b P=%h", bus.busy, bus.done, bus.P);
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL midreset_flags: busy=%b done=%b, expected 0 0", bus.busy, bus.done);
        end
        tests++;
        if (bus.P !== 16'h0000) begin
            fails++;
            $display("FAIL midreset_p: P=%h, expected 0000", bus.P);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_op("after_reset_5x6", 8'd5, 8'd6, 16'h001E, 9);
    endtask

    task automatic test_zero();
        run_op("zero_m", 8'h00, 8'h77, 16'h0000, ZERO_DONE);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.M     = '0;
        bus.Q     = '0;
        test_reset();
        test_basic();
        test_signed();
        test_extra_bit();
        test_back_to_back();
        test_reset_mid();
        test_zero();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
